// File: rtl/dnn_pkg.sv
// dnn_pkg: shared widths and vector types for the layer-1 MAC / ReLU boundary.
package dnn_pkg;
    localparam int MAC_W = 17;
    localparam int ACT_W = 7;
    localparam int SHIFT_DEF = 6;
    typedef logic [3:0][ACT_W-1:0] act_vec_t;
    typedef logic [3:0][MAC_W-1:0] mac_vec_t;
endpackage

// File: rtl/dnn_relu_requant.sv
// dnn_relu_requant: single-lane ReLU, right-shift requantize and saturate.
// DNN_RELU_ROUND_EN selects round-half-up instead of truncation before the shift.
module dnn_relu_requant #(
    parameter int IN_SIZE = 17,
    parameter int OUT_SIZE = 7,
    parameter int SHIFT = 6
) (
    input  logic [IN_SIZE-1:0]  v,
    output logic [OUT_SIZE-1:0] y
);
    localparam logic signed [IN_SIZE:0] MAX = (IN_SIZE+1)'(2**(OUT_SIZE-1)-1);
`ifdef DNN_RELU_ROUND_EN
    localparam logic signed [IN_SIZE:0] HALF = (IN_SIZE+1)'(2**(SHIFT-1));
`else
    localparam logic signed [IN_SIZE:0] HALF = '0;
`endif
    logic signed [IN_SIZE:0] ext, r;
    // one extra bit keeps the rounding add from wrapping at the positive limit
    assign ext = $signed({v[IN_SIZE-1], v});
    assign r = (ext + HALF) >>> SHIFT;
    assign y = v[IN_SIZE-1] ? '0 : (r > MAX ? MAX[OUT_SIZE-1:0] : r[OUT_SIZE-1:0]);
endmodule

// File: rtl/dnn_layer1_relu_sink.sv
// dnn_layer1_relu_sink: captures MAC sums, applies ReLU/requantize, buffers in a FIFO.
// Rounding mode follows the DNN_RELU_ROUND_EN macro inside dnn_relu_requant.
module dnn_layer1_relu_sink
    import dnn_pkg::*;
#(
    parameter int IN_SIZE = MAC_W,
    parameter int OUT_SIZE = ACT_W,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mac_ready,
    input  logic [IN_SIZE-1:0]         in4,
    input  logic [IN_SIZE-1:0]         in5,
    input  logic [IN_SIZE-1:0]         in6,
    input  logic [IN_SIZE-1:0]         in7,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_SIZE-1:0]        y4,
    output logic [OUT_SIZE-1:0]        y5,
    output logic [OUT_SIZE-1:0]        y6,
    output logic [OUT_SIZE-1:0]        y7,
    output logic                       hold,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    mac_vec_t din;
    act_vec_t wdata, head;
    act_vec_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_nxt;
    logic push, pop;
    assign din = {in7, in6, in5, in4};
    for (genvar i = 0; i < 4; i++) begin : g_lane
        dnn_relu_requant #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .SHIFT(SHIFT)) u_lane (
            .v(din[i]),
            .y(wdata[i])
        );
    end
    assign out_valid = count != '0;
    assign pop = out_valid && out_ready;
    // a pop frees a slot in the same cycle, so a full FIFO still accepts
    assign push = mac_ready && (count != CW'(DEPTH) || pop);
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign head = mem[rd_ptr];
    assign y4 = out_valid ? head[0] : '0;
    assign y5 = out_valid ? head[1] : '0;
    assign y6 = out_valid ? head[2] : '0;
    assign y7 = out_valid ? head[3] : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
            hold <= count_nxt == CW'(DEPTH);
            overflow <= overflow || (mac_ready && !push);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule
